weight_mem_arbiter: RTL

Round-robin arbiter that shares the single-port weight/feature buffer memory among several read requesters, such as convolution engine lanes and the detection-head loader. It accepts burst read requests, serialises them onto the memory port with no bubbles between bursts, and routes the returned data to the owning requester. It sits between the compute datapath and the on-chip buffer, in the clk domain.

---
 rtl/ssd_pkg.sv | 21 ++
 rtl/weight_mem_arbiter_rr_pick.sv | 43 ++++
 rtl/weight_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ssd_pkg : shared arbiter state type and datapath width defaults  | rev 1.0
// ----------------------------------------------------------------------------
package ssd_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_e;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/weight_mem_arbiter_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_pick : combinational rotating-priority selector starting at ptr  | rev 1.0
// ----------------------------------------------------------------------------
module rr_pick
  import ssd_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] idx,
  output logic [N-1:0]    onehot
);

  logic [N-1:0]    cand;
  logic [ID_W-1:0] pos;

  assign cand = req & ~mask;

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = '0;
    // Walk from the farthest offset down so the candidate nearest ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      pos = ID_W'((int'(ptr) + k) % N);
      if (cand[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
    if (any) begin
      onehot = N'(1) << idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/weight_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// weight_mem_arbiter : round-robin burst read arbiter for the weight buffer  | rev 1.0
// ----------------------------------------------------------------------------
module weight_mem_arbiter
  import ssd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_last,
  output logic                      busy
);

  localparam int ID_W   = idx_w(NUM_REQ);
  localparam int STAGES = RD_LAT + 1;

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d, owner_q, owner_d;
  logic [ADDR_W-1:0]   base_q, base_d, mem_addr_q, mem_addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d, idx_q, idx_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                mem_en_q, mem_en_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic [STAGES-1:0]   pv_q, pv_d, pl_q, pl_d;
  logic [ID_W-1:0]     pid_q [STAGES];
  logic [ID_W-1:0]     pid_d [STAGES];

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [LEN_W-1:0]    len_arr  [NUM_REQ];

  logic                is_last, pick_any;
  logic [ID_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]  pick_oh, pick_mask;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign len_arr[i]  = req_len[i*LEN_W +: LEN_W];
  end

  assign is_last   = (state_q == ARB_ISSUE) && (idx_q == cnt_q);
  // The running owner is excluded at its last word so a lingering req is not regranted.
  assign pick_mask = (state_q == ARB_ISSUE) ? (NUM_REQ'(1) << owner_q) : '0;

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req    (req),
    .mask   (pick_mask),
    .ptr    (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    gnt_d      = '0;
    mem_en_d   = mem_en_q;
    mem_addr_d = mem_addr_q;

    if ((state_q == ARB_ISSUE) && !is_last) begin
      idx_d      = idx_q + LEN_W'(1);
      mem_addr_d = base_q + ADDR_W'(idx_d);
    end

    if ((state_q == ARB_IDLE) || is_last) begin
      if (pick_any) begin
        state_d    = ARB_ISSUE;
        owner_d    = pick_idx;
        ptr_d      = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
        base_d     = addr_arr[pick_idx];
        cnt_d      = len_arr[pick_idx];
        idx_d      = '0;
        gnt_d      = pick_oh;
        mem_en_d   = 1'b1;
        mem_addr_d = addr_arr[pick_idx];
      end else begin
        state_d    = ARB_IDLE;
        idx_d      = '0;
        mem_en_d   = 1'b0;
        mem_addr_d = '0;
      end
    end
  end

  // Return tags travel alongside the memory latency; stage RD_LAT-1 lines up with mem_rdata.
  for (genvar s = 0; s < STAGES; s++) begin : g_ret
    if (s == 0) begin : g_head
      assign pv_d[s]  = mem_en_q;
      assign pl_d[s]  = is_last;
      assign pid_d[s] = owner_q;
    end else begin : g_shift
      assign pv_d[s]  = pv_q[s-1];
      assign pl_d[s]  = pl_q[s-1];
      assign pid_d[s] = pid_q[s-1];
    end
  end

  assign rd_data_d = pv_q[STAGES-2] ? mem_rdata : rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      gnt_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      rd_data_q  <= '0;
      pv_q       <= '0;
      pl_q       <= '0;
      for (int s = 0; s < STAGES; s++) begin
        pid_q[s] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      gnt_q      <= gnt_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      rd_data_q  <= rd_data_d;
      pv_q       <= pv_d;
      pl_q       <= pl_d;
      for (int s = 0; s < STAGES; s++) begin
        pid_q[s] <= pid_d[s];
      end
    end
  end

  assign gnt      = gnt_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = pv_q[STAGES-1] ? (NUM_REQ'(1) << pid_q[STAGES-1]) : '0;
  assign rd_last  = pv_q[STAGES-1] & pl_q[STAGES-1];
  assign busy     = (state_q != ARB_IDLE) | (|pv_q);

endmodule
`default_nettype wire
